bitcoin_nonce_scanner: RTL
==========================

# bitcoin_nonce_scanner

Parametrised successor to the serial bitcoin hasher. It reads one 19-word block header from the shared word memory once and computes the phase-1 midstate once. It then sweeps `NUM_NONCES` consecutive nonces through SHA-256d, writing each final H0 word to memory. New over the serial hasher: configurable nonce count and start nonce, a runtime difficulty `target` compare with `found` / `found_nonce` reporting, and optional early stop on the first hit.

## Interface
- `NUM_NONCES`, 16: nonces scanned per start; legal range 1..256.
- `START_NONCE`, 0: 32-bit first nonce value.
- `STOP_ON_FOUND`, 0: when 1, the scan ends after writing the first nonce whose H0 < `target`.
- `clk`  in  1  sole clock; `mem_clk` is driven from it.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE.
- `start`  in  1  sampled only in IDLE.
- `message_addr`  in  16  base address of header words 0..18.
- `output_addr`  in  16  base address for the H0 results.
- `target`  in  32  a nonce is a hit when its final H0 < `target` (unsigned).
- `done`  out  1  one-cycle pulse at scan end.
- `found`  out  1  sticky hit flag; cleared on `start`.
- `found_nonce`  out  32  first hit nonce; valid while `found`=1.
- `mem_clk`  out  1  equals `clk`.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  16  word address.
- `mem_write_data`  out  32  write data.
- `mem_read_data`  in  32  read data, valid one cycle after the address is driven.

## Operation
- States:
  - IDLE → READ on `start`.
  - READ (20 cycles) → BLK1.
  - BLK1 (66 cycles) → BLK2.
  - BLK2 (66 cycles) → BLK3.
  - BLK3 (66 cycles) → WRITE.
  - WRITE (1 cycle) → BLK2 (next nonce) or DONE.
  - DONE (1 cycle) → IDLE.
- READ:
  - Drives `message_addr`+k on cycle k, for k = 0..18.
  - Captures word k on cycle k+1.
  - Words 16..18 are kept in a 3-word tail register.
- Block sub-sequence, 66 cycles:
  - LOAD: 1 cycle; sets w[0..15] and the working vars A..H.
  - ROUND: 64 cycles; one compression round per cycle.
  - UPDATE: 1 cycle; h += A..H.
- Message schedule: 16-entry circular buffer; word t≥16 is computed in place at index t mod 16 during round t.
- BLK1:
  - Input: IV and header words 0..15.
  - Result is stored as `midstate`; it is not recomputed per nonce.
- BLK2:
  - h ← `midstate`.
  - w = tail[0..2], nonce, 0x80000000, zeros (w[5..14]), 640.
- BLK3:
  - h ← IV.
  - w = BLK2 result h[0..7], 0x80000000, zeros (w[9..14]), 256.
- WRITE, for nonce index i:
  - `mem_we`=1, `mem_addr`=`output_addr`+i, `mem_write_data`=BLK3 H0.
  - If H0 < `target` and `found`=0: set `found`, latch `found_nonce`.
  - If `STOP_ON_FOUND`=1 and a hit occurred this cycle, or i = `NUM_NONCES`−1: go to DONE.
  - Otherwise increment i and the nonce.
- Arithmetic and widths:
  - All SHA additions are mod 2^32.
  - Nonce = `START_NONCE`+i, wraps mod 2^32.
  - Output address wraps mod 2^16.
  - i is an 8-bit counter.
- `message_addr`, `output_addr`, `target` are sampled at `start` and held internally; changes mid-scan are ignored.
- `start` outside IDLE is ignored; it is not queued.
- `mem_we` is high only in WRITE; no reads are issued outside READ.

## Timing
- Reset values:
  - `done`=0, `found`=0, `found_nonce`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_write_data`=0.
  - state = IDLE.
- `reset` asserted mid-scan: same as above, asynchronously. A WRITE in flight is aborted and `mem_we` drops immediately.
- Full-scan latency: `done` is high in cycle 20+66+133·N+1 after the `start` sample edge, for N = `NUM_NONCES`; N=16 gives 2215.
- Early stop at hit index j: the same formula with N=j+1.
- Per-nonce cost: 133 cycles; exactly one write per nonce.
- `found` and `found_nonce` update in the WRITE cycle; they hold until the next accepted `start`.

## Test plan
- Golden header, N=16, START_NONCE=0, `target`=0:
  - 16 writes to `output_addr`..+15 matching the software SHA256d model.
  - `found`=0; `done` at cycle 2215.
- Same header, `target`=0xFFFFFFFF, STOP_ON_FOUND=1:
  - Exactly one write, at `output_addr`.
  - `found`=1, `found_nonce`=0; `done` at cycle 220.
- START_NONCE=0xFFFFFFFE, N=4:
  - Nonces used: FFFFFFFE, FFFFFFFF, 0, 1.
  - H0 values match the model.
- `output_addr`=0xFFFE, N=4: writes go to FFFE, FFFF, 0000, 0001.
- `target` set to the model's H0 for nonce 5 plus 1, STOP_ON_FOUND=0:
  - `found_nonce`=5 (assuming no earlier hit in the model).
  - All 16 writes still occur.
- `reset` pulsed at cycle 1000:
  - `mem_we`=0 and all outputs 0 immediately.
  - A new `start` reproduces the full result set.
  - `start` pulsed mid-scan has no effect.

Source files
------------

// File: rtl/bitcoin_nonce_scanner.sv
// SHA-256d nonce scanner: reads one 19-word header, computes the midstate once, then hashes
// NUM_NONCES consecutive nonces, writing each final H0 and flagging the first H0 below target.
module bitcoin_nonce_scanner #(
    parameter int unsigned NUM_NONCES    = 16,
    parameter logic [31:0] START_NONCE   = 32'h0,
    parameter bit          STOP_ON_FOUND = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    input  logic [31:0] target,
    output logic        done,
    output logic        found,
    output logic [31:0] found_nonce,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {StIdle, StRead, StBlk1, StBlk2, StBlk3, StWrite, StDone} state_e;

    localparam logic [7:0] LastIdx = 8'(NUM_NONCES - 1);

    localparam logic [31:0] IvTab [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KTab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [15:0] msg_addr_q, msg_addr_d, out_addr_q, out_addr_d;
    logic [31:0] target_q, target_d;
    logic [31:0] tail_q [3], tail_d [3];
    logic [31:0] w_q [16], w_d [16];
    logic [31:0] wv_q [8], wv_d [8];
    logic [31:0] h_q [8], h_d [8];
    logic [31:0] mid_q [8], mid_d [8];
    logic [7:0]  idx_q, idx_d;
    logic [31:0] nonce_q, nonce_d;
    logic        found_q, found_d;
    logic [31:0] found_nonce_q, found_nonce_d;

    // Datapath for one compression round; cnt 1..64 maps to round t = 0..63.
    logic [5:0]  rnd_t;
    logic [3:0]  i0, i2, i7, i15;
    logic [31:0] sched_w, w_t, t1, t2;
    logic [31:0] rnd_v [8];
    logic [31:0] h_sum [8];
    logic        new_hit;

    always_comb begin
        rnd_t   = 6'(cnt_q - 7'd1);
        i0      = rnd_t[3:0];
        i2      = i0 - 4'd2;
        i7      = i0 - 4'd7;
        i15     = i0 - 4'd15;
        sched_w = ssig1(w_q[i2]) + w_q[i7] + ssig0(w_q[i15]) + w_q[i0];
        w_t     = (rnd_t[5:4] == 2'b00) ? w_q[i0] : sched_w;
        t1      = wv_q[7] + bsig1(wv_q[4]) + ((wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]))
                  + KTab[rnd_t] + w_t;
        t2      = bsig0(wv_q[0]) + ((wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]));
        rnd_v[0] = t1 + t2;
        rnd_v[1] = wv_q[0];
        rnd_v[2] = wv_q[1];
        rnd_v[3] = wv_q[2];
        rnd_v[4] = wv_q[3] + t1;
        rnd_v[5] = wv_q[4];
        rnd_v[6] = wv_q[5];
        rnd_v[7] = wv_q[6];
        for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + wv_q[i];
    end

    assign new_hit = (state_q == StWrite) && (h_q[0] < target_q) && !found_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        msg_addr_d    = msg_addr_q;
        out_addr_d    = out_addr_q;
        target_d      = target_q;
        tail_d        = tail_q;
        w_d           = w_q;
        wv_d          = wv_q;
        h_d           = h_q;
        mid_d         = mid_q;
        idx_d         = idx_q;
        nonce_d       = nonce_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        done           = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = 16'h0;
        mem_write_data = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    msg_addr_d    = message_addr;
                    out_addr_d    = output_addr;
                    target_d      = target;
                    found_d       = 1'b0;
                    found_nonce_d = 32'h0;
                    idx_d         = 8'h0;
                    nonce_d       = START_NONCE;
                    cnt_d         = 7'd0;
                    state_d       = StRead;
                end
            end
            StRead: begin
                if (cnt_q < 7'd19) mem_addr = msg_addr_q + 16'(cnt_q);
                // Read data lags the address by one cycle.
                if (cnt_q >= 7'd1 && cnt_q <= 7'd16) begin
                    w_d[4'(cnt_q - 7'd1)] = mem_read_data;
                end else if (cnt_q >= 7'd17) begin
                    tail_d[2'(cnt_q - 7'd17)] = mem_read_data;
                end
                if (cnt_q == 7'd19) begin
                    cnt_d   = 7'd0;
                    state_d = StBlk1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            StBlk1, StBlk2, StBlk3: begin
                if (cnt_q == 7'd0) begin
                    if (state_q == StBlk1) begin
                        h_d  = IvTab;
                        wv_d = IvTab;
                    end else if (state_q == StBlk2) begin
                        h_d  = mid_q;
                        wv_d = mid_q;
                        for (int i = 0; i < 3; i++) w_d[i] = tail_q[i];
                        w_d[3] = nonce_q;
                        w_d[4] = 32'h8000_0000;
                        for (int i = 5; i < 15; i++) w_d[i] = 32'h0;
                        w_d[15] = 32'd640;
                    end else begin
                        for (int i = 0; i < 8; i++) w_d[i] = h_q[i];
                        w_d[8] = 32'h8000_0000;
                        for (int i = 9; i < 15; i++) w_d[i] = 32'h0;
                        w_d[15] = 32'd256;
                        h_d  = IvTab;
                        wv_d = IvTab;
                    end
                end else if (cnt_q <= 7'd64) begin
                    wv_d = rnd_v;
                    if (rnd_t[5:4] != 2'b00) w_d[i0] = sched_w;
                end else begin
                    h_d = h_sum;
                    if (state_q == StBlk1) mid_d = h_sum;
                end
                if (cnt_q == 7'd65) begin
                    cnt_d = 7'd0;
                    if (state_q == StBlk1) state_d = StBlk2;
                    else if (state_q == StBlk2) state_d = StBlk3;
                    else state_d = StWrite;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            StWrite: begin
                mem_we         = 1'b1;
                mem_addr       = out_addr_q + 16'(idx_q);
                mem_write_data = h_q[0];
                if (new_hit) begin
                    found_d       = 1'b1;
                    found_nonce_d = nonce_q;
                end
                if ((STOP_ON_FOUND && new_hit) || idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 8'd1;
                    nonce_d = nonce_q + 32'd1;
                    cnt_d   = 7'd0;
                    state_d = StBlk2;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            cnt_q         <= 7'd0;
            msg_addr_q    <= 16'h0;
            out_addr_q    <= 16'h0;
            target_q      <= 32'h0;
            idx_q         <= 8'h0;
            nonce_q       <= 32'h0;
            found_q       <= 1'b0;
            found_nonce_q <= 32'h0;
            for (int i = 0; i < 3; i++) tail_q[i] <= 32'h0;
            for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
            for (int i = 0; i < 8; i++) begin
                wv_q[i]  <= 32'h0;
                h_q[i]   <= 32'h0;
                mid_q[i] <= 32'h0;
            end
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            msg_addr_q    <= msg_addr_d;
            out_addr_q    <= out_addr_d;
            target_q      <= target_d;
            idx_q         <= idx_d;
            nonce_q       <= nonce_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            tail_q        <= tail_d;
            w_q           <= w_d;
            wv_q          <= wv_d;
            h_q           <= h_d;
            mid_q         <= mid_d;
        end
    end

    assign found       = found_q;
    assign found_nonce = found_nonce_q;
    assign mem_clk     = clk;

endmodule
